// File: rtl/divider_seq.sv
// divider_seq: iterative restoring divider, 2*WIDTH-bit dividend by WIDTH-bit
// divisor, STEPS_PER_CYCLE quotient bits per clock, valid/ready on both sides.
// Divide-by-zero and quotient overflow are detected at accept time and skip
// the iteration entirely.
// Optional feature: define SIGNED_DIV_EN to add the signed_mode input
// (two's complement operands, truncating quotient, FIXUP state).
// STEPS_PER_CYCLE must be 1, 2 or 4 and must divide WIDTH.
module divider_seq #(
  parameter int WIDTH           = 32,
  parameter int STEPS_PER_CYCLE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
`ifdef SIGNED_DIV_EN
  input  logic                 signed_mode,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 error_divide_by_zero,
  output logic                 overflow,
  output logic                 busy
);

  localparam int ITERS = WIDTH / STEPS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITERS + 1);

`ifdef SIGNED_DIV_EN
  typedef enum logic [1:0] {IDLE, CALC, DONE, FIXUP} state_t;
  localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};
`else
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`endif

  state_t             state_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [WIDTH-1:0]   rem_reg;      // partial remainder, always < divisor_reg
  logic [WIDTH-1:0]   qd_reg;       // low dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]   divisor_reg;
  logic [WIDTH-1:0]   quotient_reg;
  logic [WIDTH-1:0]   remainder_reg;
  logic               out_valid_reg;
  logic               dbz_reg;
  logic               ovf_reg;

  // Operand magnitudes: in unsigned operation these are the operands themselves.
  logic [2*WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0]   dvs_mag;

`ifdef SIGNED_DIV_EN
  logic dvd_neg;
  logic dvs_neg;
  logic signed_reg;
  logic neg_q_reg;
  logic neg_r_reg;

  assign dvd_neg = signed_mode & dividend[2*WIDTH-1];
  assign dvs_neg = signed_mode & divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? -dividend : dividend;
  assign dvs_mag = dvs_neg ? -divisor : divisor;
`else
  assign dvd_mag = dividend;
  assign dvs_mag = divisor;
`endif

  // Chain of STEPS_PER_CYCLE restoring steps evaluated within one clock.
  logic [WIDTH-1:0] st_rem [0:STEPS_PER_CYCLE];
  logic [WIDTH-1:0] st_qd  [0:STEPS_PER_CYCLE];

  assign st_rem[0] = rem_reg;
  assign st_qd[0]  = qd_reg;

  generate
    for (genvar gi = 0; gi < STEPS_PER_CYCLE; gi++) begin : g_step
      logic [WIDTH:0] shifted;
      logic [WIDTH:0] diff;
      // shifted < 2*divisor, so the borrow bit of diff is exactly "shifted < divisor".
      assign shifted        = {st_rem[gi], st_qd[gi][WIDTH-1]};
      assign diff           = shifted - {1'b0, divisor_reg};
      assign st_rem[gi + 1] = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
      assign st_qd[gi + 1]  = {st_qd[gi][WIDTH-2:0], ~diff[WIDTH]};
    end
  endgenerate

  assign in_ready             = rst_n && (state_reg == IDLE);
  assign busy                 = (state_reg != IDLE);
  assign out_valid            = out_valid_reg;
  assign quotient             = quotient_reg;
  assign remainder            = remainder_reg;
  assign error_divide_by_zero = dbz_reg;
  assign overflow             = ovf_reg;

  // Control FSM, iteration datapath and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      rem_reg       <= '0;
      qd_reg        <= '0;
      divisor_reg   <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      out_valid_reg <= 1'b0;
      dbz_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
`ifdef SIGNED_DIV_EN
      signed_reg    <= 1'b0;
      neg_q_reg     <= 1'b0;
      neg_r_reg     <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            if (divisor == '0) begin
              state_reg     <= DONE;
              out_valid_reg <= 1'b1;
              dbz_reg       <= 1'b1;
              ovf_reg       <= 1'b0;
              quotient_reg  <= '1;
              remainder_reg <= dividend[WIDTH-1:0];
            end else if (dvd_mag[2*WIDTH-1:WIDTH] >= dvs_mag) begin
              // Magnitude quotient needs more than WIDTH bits.
              state_reg     <= DONE;
              out_valid_reg <= 1'b1;
              dbz_reg       <= 1'b0;
              ovf_reg       <= 1'b1;
              quotient_reg  <= '1;
              remainder_reg <= '0;
            end else begin
              state_reg   <= CALC;
              count_reg   <= CNT_W'(ITERS);
              rem_reg     <= dvd_mag[2*WIDTH-1:WIDTH];
              qd_reg      <= dvd_mag[WIDTH-1:0];
              divisor_reg <= dvs_mag;
              dbz_reg     <= 1'b0;
              ovf_reg     <= 1'b0;
`ifdef SIGNED_DIV_EN
              signed_reg  <= signed_mode;
              neg_q_reg   <= dvd_neg ^ dvs_neg;
              neg_r_reg   <= dvd_neg;
`endif
            end
          end
        end
        CALC: begin
          rem_reg   <= st_rem[STEPS_PER_CYCLE];
          qd_reg    <= st_qd[STEPS_PER_CYCLE];
          count_reg <= count_reg - CNT_W'(1);
          if (count_reg == CNT_W'(1)) begin
`ifdef SIGNED_DIV_EN
            if (signed_reg) begin
              state_reg <= FIXUP;
            end else
`endif
            begin
              state_reg     <= DONE;
              out_valid_reg <= 1'b1;
              quotient_reg  <= st_qd[STEPS_PER_CYCLE];
              remainder_reg <= st_rem[STEPS_PER_CYCLE];
            end
          end
        end
`ifdef SIGNED_DIV_EN
        FIXUP: begin
          // Apply signs to the magnitude result and range-check the signed quotient.
          state_reg     <= DONE;
          out_valid_reg <= 1'b1;
          if (neg_q_reg ? (qd_reg > HALF) : qd_reg[WIDTH-1]) begin
            ovf_reg       <= 1'b1;
            quotient_reg  <= '1;
            remainder_reg <= '0;
          end else begin
            quotient_reg  <= neg_q_reg ? -qd_reg : qd_reg;
            remainder_reg <= neg_r_reg ? -rem_reg : rem_reg;
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_seq.sv
// tb_divider_seq: directed table-driven checks of divider_seq (WIDTH=8,
// STEPS_PER_CYCLE=1) plus hand-written backpressure and mid-op reset sequences.
// Signed vectors are added when SIGNED_DIV_EN is defined.
module tb_divider_seq;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2*W-1:0] dividend = '0;
  logic [W-1:0]   divisor = '0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           error_divide_by_zero;
  logic           overflow;
  logic           busy;
`ifdef SIGNED_DIV_EN
  logic           signed_mode = 1'b0;
`endif

  divider_seq #(.WIDTH(W), .STEPS_PER_CYCLE(1)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .dividend             (dividend),
    .divisor              (divisor),
`ifdef SIGNED_DIV_EN
    .signed_mode          (signed_mode),
`endif
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .quotient             (quotient),
    .remainder            (remainder),
    .error_divide_by_zero (error_divide_by_zero),
    .overflow             (overflow),
    .busy                 (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2*W-1:0] dvd;
    logic [W-1:0]   dvs;
    logic           sm;
    logic [W-1:0]   q;
    logic [W-1:0]   r;
    logic           err;
    logic           ovf;
    int             lat;  // edges from the accepting edge (inclusive) to out_valid
  } vec_t;

  vec_t vecs[$];

  // Apply one operation with out_ready held high and check result, flags and timing.
  task automatic run_op(input vec_t v, input string tag);
    int waitc = 0;
    int lat;
    @(negedge clk);
    while (!in_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) begin
      check({tag, "_in_ready_wait"}, 32'(in_ready), 32'd1);
      return;
    end
    dividend  = v.dvd;
    divisor   = v.dvs;
`ifdef SIGNED_DIV_EN
    signed_mode = v.sm;
`endif
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(v.lat));
    if (!out_valid) return;
    check({tag, "_q"},   32'(quotient), 32'(v.q));
    check({tag, "_r"},   32'(remainder), 32'(v.r));
    check({tag, "_dbz"}, 32'(error_divide_by_zero), 32'(v.err));
    check({tag, "_ovf"}, 32'(overflow), 32'(v.ovf));
    @(posedge clk);
    #1;
    check({tag, "_drop"}, 32'(out_valid), 32'd0);
    $display("op %s: %0h / %0h -> q=%0h r=%0h dbz=%0b ovf=%0b lat=%0d",
             tag, v.dvd, v.dvs, v.q, v.r, v.err, v.ovf, lat);
  endtask

  initial begin
    int wc;
    //          dvd        dvs    sm    q      r      err   ovf  lat
    vecs.push_back('{16'd1000, 8'd9,   1'b0, 8'd111, 8'd1,  1'b0, 1'b0, 9});
    vecs.push_back('{16'h1234, 8'd0,   1'b0, 8'hFF,  8'h34, 1'b1, 1'b0, 1});
    vecs.push_back('{16'h0A00, 8'h05,  1'b0, 8'hFF,  8'h00, 1'b0, 1'b1, 1});
    vecs.push_back('{16'd100,  8'd7,   1'b0, 8'd14,  8'd2,  1'b0, 1'b0, 9});
    vecs.push_back('{16'h04FF, 8'h05,  1'b0, 8'hFF,  8'h04, 1'b0, 1'b0, 9});
    vecs.push_back('{16'h0500, 8'h05,  1'b0, 8'hFF,  8'h00, 1'b0, 1'b1, 1});
    vecs.push_back('{16'd0,    8'd3,   1'b0, 8'd0,   8'd0,  1'b0, 1'b0, 9});
    vecs.push_back('{16'hFFFE, 8'hFF,  1'b0, 8'hFF,  8'h00, 1'b0, 1'b1, 1});
    vecs.push_back('{16'hFEFF, 8'hFF,  1'b0, 8'hFF,  8'hFE, 1'b0, 1'b0, 9});
    vecs.push_back('{16'h0007, 8'h00,  1'b0, 8'hFF,  8'h07, 1'b1, 1'b0, 1});
`ifdef SIGNED_DIV_EN
    vecs.push_back('{16'hFF9C, 8'd7,   1'b1, 8'hF2,  8'hFE, 1'b0, 1'b0, 10}); // -100 / 7
    vecs.push_back('{16'hFF80, 8'hFF,  1'b1, 8'hFF,  8'h00, 1'b0, 1'b1, 10}); // -128 / -1
    vecs.push_back('{16'd100,  8'hF9,  1'b1, 8'hF2,  8'h02, 1'b0, 1'b0, 10}); // 100 / -7
    vecs.push_back('{16'hFF80, 8'd1,   1'b1, 8'h80,  8'h00, 1'b0, 1'b0, 10}); // -128 / 1
    vecs.push_back('{16'h0080, 8'd1,   1'b1, 8'hFF,  8'h00, 1'b0, 1'b1, 10}); // 128 / 1
    vecs.push_back('{16'h1234, 8'd0,   1'b1, 8'hFF,  8'h34, 1'b1, 1'b0, 1});
`endif

    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_quotient",  32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_dbz",       32'(error_divide_by_zero), 32'd0);
    check("rst_ovf",       32'(overflow), 32'd0);
    check("rst_busy",      32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release_in_ready", 32'(in_ready), 32'd1);

    // Table-driven vectors
    foreach (vecs[i]) run_op(vecs[i], $sformatf("v%0d", i));

    // Backpressure: 100/7 held for 5 cycles, in_valid pulses must be ignored.
    @(negedge clk);
    dividend  = 16'd100;
    divisor   = 8'd7;
`ifdef SIGNED_DIV_EN
    signed_mode = 1'b0;
`endif
    out_ready = 1'b0;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wc = 0;
    while (!out_valid && wc < 40) begin
      @(posedge clk);
      #1;
      wc++;
    end
    check("bp_out_valid_rise", 32'(out_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      dividend = 16'd50;
      divisor  = 8'd5;
      @(posedge clk);
      #1;
      check($sformatf("bp%0d_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d_q", k),     32'(quotient), 32'd14);
      check($sformatf("bp%0d_r", k),     32'(remainder), 32'd2);
      check($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'd0);
      $display("bp hold %0d: q=%0d r=%0d out_valid=%0b", k, quotient, remainder, out_valid);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_busy",  32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check("bp_no_capture", 32'(busy), 32'd0);

    // Reset mid-op: abort during the 4th CALC cycle.
    @(negedge clk);
    dividend = 16'd1000;
    divisor  = 8'd9;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("mid_busy",     32'(busy), 32'd1);
    check("mid_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",      32'(busy), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_q",         32'(quotient), 32'd0);
    check("mid_rst_r",         32'(remainder), 32'd0);
    check("mid_rst_flags",     32'({error_divide_by_zero, overflow}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_release_in_ready", 32'(in_ready), 32'd1);
    run_op(vecs[0], "after_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
